conv_ctrl: RTL and testbench
============================

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports i_clk and i_rst as below.
REQ-002 The block SHALL provide the ports below (name, direction, width, meaning); all data is two's complement.
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  one-cycle start pulse; sampled only in IDLE
- i_mode  in  1  1 = depthwise (3 independent channels), 0 = standard (sum over channel groups)
- i_numPix  in  12  output pixels in job (unsigned)
- i_numGrp  in  6  3-channel groups per pixel, mode 0 only (unsigned)
- i_bias  in  10  signed bias, added to every output
- i_relu  in  1  1 = clamp negative results to 0
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle job-complete pulse
- o_opcode  out  1  to conv datapath; equals latched mode
- o_rdReq  out  1  window/weight fetch request
- o_pixIdx  out  12  pixel index of current fetch
- o_grpIdx  out  6  group index of current fetch
- i_rdAck  in  1  buses loaded; conv results valid this cycle
- i_conv0, i_conv1, i_conv2  in  10 each  conv datapath outputs
- o_outValid  out  1  output word valid
- i_outReady  in  1  downstream accepts
- o_outData0, o_outData1, o_outData2  out  10 each  results

Function
REQ-003 States SHALL be IDLE, FETCH, OUT, DONE.
REQ-004 IDLE: on i_start, latch mode, numPix, numGrp (0 treated as 1), bias, relu; clear indices and accumulator; next state FETCH, or DONE if i_numPix==0.
REQ-005 FETCH: o_rdReq=1 every cycle; a transfer occurs on each cycle with i_rdAck=1; back-to-back acks SHALL yield one transfer per cycle.
REQ-006 Mode 1 transfer: capture i_conv0..2; go OUT.
REQ-007 Mode 0 transfer: acc (16-bit signed) += sign-extended i_conv0; if o_grpIdx==numGrp-1 go OUT, else o_grpIdx+1 and stay FETCH.
REQ-008 Result: r = sat10(value + bias), computed at >=16 bits, saturated to [-512,511]; then, if relu, r<0 -> 0.
REQ-009 Mode 1: o_outDataK = result of captured i_convK; mode 0: o_outData0 = result of acc, o_outData1 = o_outData2 = 0.
REQ-010 OUT: o_outValid=1, outputs held stable until i_outReady=1; on handshake clear acc and o_grpIdx; if o_pixIdx==numPix-1 go DONE, else o_pixIdx+1 and go FETCH.
REQ-011 DONE: o_done=1 for exactly one cycle, then IDLE.
REQ-012 i_start outside IDLE SHALL be ignored; input config changes during a job SHALL have no effect.
REQ-013 o_rdReq and o_outValid SHALL never be high in the same cycle; i_rdAck outside FETCH SHALL be ignored.
REQ-014 Latency: i_start at edge N -> o_rdReq=1 after edge N; final ack -> o_outValid=1 after the next edge.

Reset
REQ-015 On i_rst, next edge: state IDLE; o_busy, o_done, o_rdReq, o_outValid = 0; o_pixIdx, o_grpIdx, o_outData0..2, acc = 0; o_opcode = 0.
REQ-016 i_rst mid-job SHALL abort immediately with no o_done pulse; i_rst overrides a simultaneous i_start.

Verification
REQ-017 Mode 1, numPix=1, bias=0, relu=0, ack with conv=43/105/142 -> one output 43/105/142, then o_done pulse.
REQ-018 Mode 0, numGrp=2, numPix=1, conv0=290 then 290 on consecutive acks -> o_outData0=511 (saturated), o_outData1/2=0.
REQ-019 Mode 0, numGrp=1, conv0=-250: bias=-10, relu=0 -> -260; relu=1 -> 0.
REQ-020 numPix=3, i_outReady low 3 cycles at pixel 1 -> outputs stable, no fetch while stalled; indices 0,1,2 in order; single o_done.
REQ-021 i_rst during FETCH of pixel 1 -> all outputs reset next edge, no o_done; i_numPix=0 start -> o_done next cycle, o_rdReq never high.

Source files
------------

// File: rtl/conv_ctrl_if.sv
// Bus bundle between the conv job controller and its surroundings:
// job configuration, fetch handshake towards the conv datapath and the
// result handshake towards the downstream consumer.
interface conv_ctrl_if;
    logic        i_start;
    logic        i_mode;
    logic [11:0] i_numPix;
    logic [5:0]  i_numGrp;
    logic [9:0]  i_bias;
    logic        i_relu;
    logic        o_busy;
    logic        o_done;
    logic        o_opcode;
    logic        o_rdReq;
    logic [11:0] o_pixIdx;
    logic [5:0]  o_grpIdx;
    logic        i_rdAck;
    logic [9:0]  i_conv0;
    logic [9:0]  i_conv1;
    logic [9:0]  i_conv2;
    logic        o_outValid;
    logic        i_outReady;
    logic [9:0]  o_outData0;
    logic [9:0]  o_outData1;
    logic [9:0]  o_outData2;

    modport slave (
        input  i_start, i_mode, i_numPix, i_numGrp, i_bias, i_relu,
        input  i_rdAck, i_conv0, i_conv1, i_conv2, i_outReady,
        output o_busy, o_done, o_opcode, o_rdReq, o_pixIdx, o_grpIdx,
        output o_outValid, o_outData0, o_outData1, o_outData2
    );

    modport master (
        output i_start, i_mode, i_numPix, i_numGrp, i_bias, i_relu,
        output i_rdAck, i_conv0, i_conv1, i_conv2, i_outReady,
        input  o_busy, o_done, o_opcode, o_rdReq, o_pixIdx, o_grpIdx,
        input  o_outValid, o_outData0, o_outData1, o_outData2
    );
endinterface

// File: rtl/conv_ctrl.sv
// Convolution job controller: walks pixels (and channel groups in standard
// mode), requests window/weight fetches, accumulates or captures the conv
// datapath results, applies bias/saturation/ReLU and hands out one result
// word per pixel.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for i_start; job configuration latched on start
// S_FETCH | o_rdReq high; each i_rdAck is one transfer
// S_OUT   | o_outValid high; result held until i_outReady
// S_DONE  | one-cycle o_done pulse, then back to S_IDLE
module conv_ctrl (
    input  logic       i_clk,
    input  logic       i_rst,
    conv_ctrl_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_OUT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [11:0] num_pix_q, num_pix_d;
    logic [5:0]  num_grp_q, num_grp_d;
    logic [9:0]  bias_q, bias_d;
    logic        relu_q, relu_d;
    logic [11:0] pix_idx_q, pix_idx_d;
    logic [5:0]  grp_idx_q, grp_idx_d;
    logic [15:0] acc_q, acc_d;
    logic [9:0]  out0_q, out0_d;
    logic [9:0]  out1_q, out1_d;
    logic [9:0]  out2_q, out2_d;

    logic        last_grp;
    logic        last_pix;
    logic [15:0] acc_sum;
    logic signed [17:0] bias_ext;

    function automatic logic signed [17:0] sext10(input logic [9:0] x);
        return {{8{x[9]}}, x};
    endfunction

    function automatic logic signed [17:0] sext16(input logic [15:0] x);
        return {{2{x[15]}}, x};
    endfunction

    // Saturate to the 10-bit signed range, then optionally clamp negatives.
    function automatic logic [9:0] post_f(input logic signed [17:0] v, input logic relu);
        logic [9:0] r;
        if (v > 18'sd511)
            r = 10'h1FF;
        else if (v < -18'sd512)
            r = 10'h200;
        else
            r = v[9:0];
        if (relu && r[9])
            r = '0;
        return r;
    endfunction

    assign last_grp = (grp_idx_q == num_grp_q - 6'd1);
    assign last_pix = (pix_idx_q == num_pix_q - 12'd1);
    assign acc_sum  = acc_q + {{6{bus.i_conv0[9]}}, bus.i_conv0};
    assign bias_ext = sext10(bias_q);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start)
                    state_d = (bus.i_numPix == 12'd0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                if (bus.i_rdAck && (mode_q || last_grp))
                    state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.i_outReady)
                    state_d = last_pix ? S_DONE : S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs straight from state and datapath registers.
    always_comb begin
        bus.o_busy     = (state_q != S_IDLE);
        bus.o_done     = (state_q == S_DONE);
        bus.o_rdReq    = (state_q == S_FETCH);
        bus.o_outValid = (state_q == S_OUT);
        bus.o_opcode   = mode_q;
        bus.o_pixIdx   = pix_idx_q;
        bus.o_grpIdx   = grp_idx_q;
        bus.o_outData0 = out0_q;
        bus.o_outData1 = out1_q;
        bus.o_outData2 = out2_q;
    end

    // Datapath next values: config latch, index walk, accumulate, result.
    // Results are registered on the final transfer so they stay frozen
    // for the whole output handshake.
    always_comb begin
        mode_d    = mode_q;
        num_pix_d = num_pix_q;
        num_grp_d = num_grp_q;
        bias_d    = bias_q;
        relu_d    = relu_q;
        pix_idx_d = pix_idx_q;
        grp_idx_d = grp_idx_q;
        acc_d     = acc_q;
        out0_d    = out0_q;
        out1_d    = out1_q;
        out2_d    = out2_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    mode_d    = bus.i_mode;
                    num_pix_d = bus.i_numPix;
                    num_grp_d = (bus.i_numGrp == 6'd0) ? 6'd1 : bus.i_numGrp;
                    bias_d    = bus.i_bias;
                    relu_d    = bus.i_relu;
                    pix_idx_d = '0;
                    grp_idx_d = '0;
                    acc_d     = '0;
                end
            end
            S_FETCH: begin
                if (bus.i_rdAck) begin
                    if (mode_q) begin
                        out0_d = post_f(sext10(bus.i_conv0) + bias_ext, relu_q);
                        out1_d = post_f(sext10(bus.i_conv1) + bias_ext, relu_q);
                        out2_d = post_f(sext10(bus.i_conv2) + bias_ext, relu_q);
                    end else begin
                        acc_d = acc_sum;
                        if (last_grp) begin
                            out0_d = post_f(sext16(acc_sum) + bias_ext, relu_q);
                            out1_d = '0;
                            out2_d = '0;
                        end else begin
                            grp_idx_d = grp_idx_q + 6'd1;
                        end
                    end
                end
            end
            S_OUT: begin
                if (bus.i_outReady) begin
                    acc_d     = '0;
                    grp_idx_d = '0;
                    if (!last_pix)
                        pix_idx_d = pix_idx_q + 12'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q    <= 1'b0;
            num_pix_q <= '0;
            num_grp_q <= '0;
            bias_q    <= '0;
            relu_q    <= 1'b0;
            pix_idx_q <= '0;
            grp_idx_q <= '0;
            acc_q     <= '0;
            out0_q    <= '0;
            out1_q    <= '0;
            out2_q    <= '0;
        end else begin
            mode_q    <= mode_d;
            num_pix_q <= num_pix_d;
            num_grp_q <= num_grp_d;
            bias_q    <= bias_d;
            relu_q    <= relu_d;
            pix_idx_q <= pix_idx_d;
            grp_idx_q <= grp_idx_d;
            acc_q     <= acc_d;
            out0_q    <= out0_d;
            out1_q    <= out1_d;
            out2_q    <= out2_d;
        end
    end

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed bench for conv_ctrl: a table of single-pixel jobs plus
// hand-written multi-pixel stall, abort and empty-job sequences.
module tb_conv_ctrl;

    typedef struct {
        logic       mode;
        logic [5:0] grp;
        logic [9:0] bias;
        logic       relu;
        logic [9:0] c0a;
        logic [9:0] c0b;
        logic [9:0] c1;
        logic [9:0] c2;
        logic [9:0] e0;
        logic [9:0] e1;
        logic [9:0] e2;
    } vec_t;

    logic i_clk;
    logic i_rst;
    int   n_pass;
    int   n_total;

    conv_ctrl_if bus ();

    conv_ctrl dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic vec_t mk(input bit mode, input int grp, input int bias, input bit relu,
                                input int c0a, input int c0b, input int c1, input int c2,
                                input int e0, input int e1, input int e2);
        vec_t v;
        v.mode = mode;
        v.grp  = 6'(grp);
        v.bias = 10'(bias);
        v.relu = relu;
        v.c0a  = 10'(c0a);
        v.c0b  = 10'(c0b);
        v.c1   = 10'(c1);
        v.c2   = 10'(c2);
        v.e0   = 10'(e0);
        v.e1   = 10'(e1);
        v.e2   = 10'(e2);
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int n_acks;
        string tag;
        tag = $sformatf("vec%0d", idx);
        n_acks = (v.mode || v.grp <= 6'd1) ? 1 : int'(v.grp);
        bus.i_mode   = v.mode;
        bus.i_numGrp = v.grp;
        bus.i_bias   = v.bias;
        bus.i_relu   = v.relu;
        bus.i_numPix = 12'd1;
        bus.i_start  = 1'b1;
        tick();
        bus.i_start  = 1'b0;
        chk({tag, "_rdreq"}, int'(bus.o_rdReq), 1);
        chk({tag, "_opcode"}, int'(bus.o_opcode), int'(v.mode));
        for (int k = 0; k < n_acks; k++) begin
            bus.i_conv0 = (k == 0) ? v.c0a : v.c0b;
            bus.i_conv1 = v.c1;
            bus.i_conv2 = v.c2;
            bus.i_rdAck = 1'b1;
            tick();
            bus.i_rdAck = 1'b0;
            if (k < n_acks - 1) begin
                chk({tag, "_grpidx"}, int'(bus.o_grpIdx), k + 1);
                chk({tag, "_rdreq_mid"}, int'(bus.o_rdReq), 1);
            end
        end
        chk({tag, "_valid"}, int'(bus.o_outValid), 1);
        chk({tag, "_rdreq_off"}, int'(bus.o_rdReq), 0);
        chk({tag, "_data0"}, int'(bus.o_outData0), int'(v.e0));
        chk({tag, "_data1"}, int'(bus.o_outData1), int'(v.e1));
        chk({tag, "_data2"}, int'(bus.o_outData2), int'(v.e2));
        bus.i_outReady = 1'b1;
        tick();
        bus.i_outReady = 1'b0;
        chk({tag, "_done"}, int'(bus.o_done), 1);
        tick();
        chk({tag, "_done_end"}, int'(bus.o_done), 0);
        chk({tag, "_busy_end"}, int'(bus.o_busy), 0);
    endtask

    vec_t vecs[9];

    initial begin
        n_pass  = 0;
        n_total = 0;
        vecs[0] = mk(1, 1,    0, 0,   43,    0,  105, 142,   43,  105, 142);
        vecs[1] = mk(0, 2,    0, 0,  290,  290,    0,   0,  511,    0,   0);
        vecs[2] = mk(0, 1,  -10, 0, -250,    0,   77,  -5, -260,    0,   0);
        vecs[3] = mk(0, 1,  -10, 1, -250,    0,    0,   0,    0,    0,   0);
        vecs[4] = mk(1, 1,  100, 1,  500,    0, -300,   5,  511,    0, 105);
        vecs[5] = mk(1, 1, -200, 0, -400,    0,   10, 300, -512, -190, 100);
        vecs[6] = mk(0, 0,    5, 0,    7,   99,    0,   0,   12,    0,   0);
        vecs[7] = mk(0, 2,    0, 0, -300, -300,    0,   0, -512,    0,   0);
        vecs[8] = mk(0, 2,   20, 1,  100,  -50,    0,   0,   70,    0,   0);

        i_rst          = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_mode     = 1'b1;
        bus.i_numPix   = 12'd0;
        bus.i_numGrp   = 6'd0;
        bus.i_bias     = 10'd0;
        bus.i_relu     = 1'b0;
        bus.i_rdAck    = 1'b0;
        bus.i_conv0    = 10'd0;
        bus.i_conv1    = 10'd0;
        bus.i_conv2    = 10'd0;
        bus.i_outReady = 1'b0;
        tick();
        tick();
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_done", int'(bus.o_done), 0);
        chk("rst_rdreq", int'(bus.o_rdReq), 0);
        chk("rst_valid", int'(bus.o_outValid), 0);
        chk("rst_opcode", int'(bus.o_opcode), 0);
        chk("rst_pix", int'(bus.o_pixIdx), 0);
        chk("rst_data0", int'(bus.o_outData0), 0);
        i_rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i], i);

        // Three pixels, stall on pixel 1 while poking start/config/ack.
        bus.i_mode   = 1'b1;
        bus.i_numGrp = 6'd1;
        bus.i_bias   = 10'd0;
        bus.i_relu   = 1'b0;
        bus.i_numPix = 12'd3;
        bus.i_start  = 1'b1;
        tick();
        bus.i_start  = 1'b0;
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("mp_pix%0d_idx", p), int'(bus.o_pixIdx), p);
            chk($sformatf("mp_pix%0d_rdreq", p), int'(bus.o_rdReq), 1);
            tick();
            chk($sformatf("mp_pix%0d_wait_rdreq", p), int'(bus.o_rdReq), 1);
            chk($sformatf("mp_pix%0d_wait_valid", p), int'(bus.o_outValid), 0);
            bus.i_conv0 = 10'(p * 10 + 1);
            bus.i_conv1 = 10'(p * 10 + 2);
            bus.i_conv2 = 10'(p * 10 + 3);
            bus.i_rdAck = 1'b1;
            tick();
            bus.i_rdAck = 1'b0;
            chk($sformatf("mp_pix%0d_valid", p), int'(bus.o_outValid), 1);
            chk($sformatf("mp_pix%0d_data0", p), int'(bus.o_outData0), p * 10 + 1);
            chk($sformatf("mp_pix%0d_data2", p), int'(bus.o_outData2), p * 10 + 3);
            if (p == 1) begin
                for (int s = 0; s < 3; s++) begin
                    bus.i_rdAck = 1'b1;
                    bus.i_start = (s == 0);
                    bus.i_bias  = 10'd100;
                    bus.i_mode  = 1'b0;
                    bus.i_conv0 = 10'd400;
                    tick();
                    chk("stall_valid", int'(bus.o_outValid), 1);
                    chk("stall_rdreq", int'(bus.o_rdReq), 0);
                    chk("stall_data0", int'(bus.o_outData0), 11);
                    chk("stall_data1", int'(bus.o_outData1), 12);
                    chk("stall_pix", int'(bus.o_pixIdx), 1);
                    chk("stall_done", int'(bus.o_done), 0);
                end
                bus.i_rdAck = 1'b0;
                bus.i_start = 1'b0;
            end
            bus.i_outReady = 1'b1;
            tick();
            bus.i_outReady = 1'b0;
            if (p < 2)
                chk($sformatf("mp_pix%0d_nodone", p), int'(bus.o_done), 0);
        end
        chk("mp_done", int'(bus.o_done), 1);
        tick();
        chk("mp_done_once", int'(bus.o_done), 0);
        chk("mp_idle", int'(bus.o_busy), 0);

        // Abort during the fetch of pixel 1.
        bus.i_mode   = 1'b1;
        bus.i_bias   = 10'd0;
        bus.i_numPix = 12'd3;
        bus.i_start  = 1'b1;
        tick();
        bus.i_start  = 1'b0;
        bus.i_conv0  = 10'd43;
        bus.i_conv1  = 10'd105;
        bus.i_conv2  = 10'd142;
        bus.i_rdAck  = 1'b1;
        tick();
        bus.i_rdAck  = 1'b0;
        bus.i_outReady = 1'b1;
        tick();
        bus.i_outReady = 1'b0;
        chk("abort_pre_pix", int'(bus.o_pixIdx), 1);
        chk("abort_pre_rdreq", int'(bus.o_rdReq), 1);
        i_rst = 1'b1;
        tick();
        chk("abort_busy", int'(bus.o_busy), 0);
        chk("abort_rdreq", int'(bus.o_rdReq), 0);
        chk("abort_valid", int'(bus.o_outValid), 0);
        chk("abort_done", int'(bus.o_done), 0);
        chk("abort_pix", int'(bus.o_pixIdx), 0);
        chk("abort_opcode", int'(bus.o_opcode), 0);
        chk("abort_data0", int'(bus.o_outData0), 0);
        chk("abort_data2", int'(bus.o_outData2), 0);
        bus.i_start = 1'b1;
        tick();
        chk("rst_over_start", int'(bus.o_busy), 0);
        bus.i_start = 1'b0;
        i_rst = 1'b0;
        tick();
        chk("abort_after_done", int'(bus.o_done), 0);
        chk("abort_after_busy", int'(bus.o_busy), 0);

        // Empty job.
        bus.i_numPix = 12'd0;
        bus.i_start  = 1'b1;
        tick();
        bus.i_start  = 1'b0;
        chk("empty_done", int'(bus.o_done), 1);
        chk("empty_rdreq", int'(bus.o_rdReq), 0);
        tick();
        chk("empty_done_end", int'(bus.o_done), 0);
        chk("empty_rdreq_end", int'(bus.o_rdReq), 0);
        chk("empty_idle", int'(bus.o_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
